// File: rtl/risc_instr_encoder.sv
// -----------------------------------------------------------------------------
// risc_instr_encoder
//   Program-load front end of the 16-bit RISC CPU. Decoded instruction fields
//   arrive over a valid/ready stream. Each beat's opcode and immediate range are
//   checked, the fields are packed into a 16-bit word, and the word is written
//   into instruction memory at consecutive addresses from start_addr.
//
// Ports
//   clk, reset            single rising-edge clock, synchronous active-high reset
//   start, start_addr     1-cycle pulse opening a load session at start_addr
//   in_valid / in_ready   beat handshake; in_ready is high only while loading
//   in_opcode .. in_imm   instruction fields, sampled on acceptance
//   in_last               final instruction of the session
//   imem_we/addr/wdata    registered write port into instruction RAM
//   busy                  session active
//   done                  session finished, held until the next start
//   err                   1-cycle pulse: previous beat rejected
//   err_count             rejected beats this session, saturating at 255
//   overflow              session ended by address wrap, sticky until start
// -----------------------------------------------------------------------------
module risc_instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_opcode,
  input  logic [2:0]        in_rs,
  input  logic [2:0]        in_rt,
  input  logic [2:0]        in_rd,
  input  logic [2:0]        in_funct,
  input  logic [11:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        err_count,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [ADDR_W-1:0] wptr_r;
  logic              accept_s;
  logic              legal_s;
  logic              wrap_s;
  logic [15:0]       word_s;

  // Opcode legality plus, for I-type, the signed 6-bit immediate range check.
  function automatic logic beat_legal(input logic [3:0] op, input logic [11:0] imm);
    logic ok;
    ok = 1'b0;
    case (op)
      4'b0000, 4'b0001, 4'b1011, 4'b1100:
        ok = (imm[11:5] == 7'b0000000) || (imm[11:5] == 7'b1111111);
      4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110,
      4'b0111, 4'b1000, 4'b1001, 4'b1101:
        ok = 1'b1;
      default:
        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Field packing per instruction format; illegal opcodes pack to zero (never written).
  function automatic logic [15:0] pack_word(input logic [3:0] op, input logic [2:0] rs,
                                            input logic [2:0] rt, input logic [2:0] rd,
                                            input logic [2:0] fn, input logic [11:0] imm);
    logic [15:0] w;
    w = 16'h0000;
    case (op)
      4'b0000, 4'b0001, 4'b1011, 4'b1100:
        w = {op, rs, rt, imm[5:0]};
      4'b1101:
        w = {op, imm};
      4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110,
      4'b0111, 4'b1000, 4'b1001:
        w = {op, rs, rt, rd, fn};
      default:
        w = 16'h0000;
    endcase
    return w;
  endfunction

  // Handshake status decoded straight from the state register.
  always_comb begin
    in_ready = (state_r == LOAD);
    busy     = (state_r == LOAD);
  end

  // Beat qualification; a concurrent start drops the beat.
  always_comb begin
    accept_s = in_valid && (state_r == LOAD) && !start;
    legal_s  = beat_legal(in_opcode, in_imm);
    word_s   = pack_word(in_opcode, in_rs, in_rt, in_rd, in_funct, in_imm);
    wrap_s   = legal_s && (wptr_r == LAST_ADDR);
  end

  // Next-state logic for the load session.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = LOAD;
        else       state_next_s = IDLE;
      end
      LOAD: begin
        if (start)                             state_next_s = LOAD;
        else if (accept_s && (in_last || wrap_s)) state_next_s = DONE;
        else                                   state_next_s = LOAD;
      end
      DONE: begin
        if (start) state_next_s = LOAD;
        else       state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_next_s;
  end

  // Write pointer, registered memory port and session status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_r     <= {ADDR_W{1'b0}};
      imem_we    <= 1'b0;
      imem_addr  <= {ADDR_W{1'b0}};
      imem_wdata <= 16'h0000;
      err        <= 1'b0;
      err_count  <= 8'd0;
      overflow   <= 1'b0;
      done       <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      err     <= 1'b0;
      if (start) begin
        wptr_r    <= start_addr;
        err_count <= 8'd0;
        overflow  <= 1'b0;
        done      <= 1'b0;
      end else begin
        // done trails entry into DONE by one cycle, i.e. the cycle after the
        // terminating write/err pulse.
        done <= (state_r == DONE);
        if (accept_s) begin
          if (legal_s) begin
            imem_we    <= 1'b1;
            imem_addr  <= wptr_r;
            imem_wdata <= word_s;
            wptr_r     <= wptr_r + ADDR_ONE;
            if (wrap_s) overflow <= 1'b1;
            else        overflow <= overflow;
          end else begin
            err <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            else                    err_count <= err_count;
          end
        end else begin
          wptr_r <= wptr_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_risc_instr_encoder.sv
module tb_risc_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last;
  logic [7:0]  start_addr;
  logic [3:0]  in_opcode;
  logic [2:0]  in_rs, in_rt, in_rd, in_funct;
  logic [11:0] in_imm;
  logic        in_ready, imem_we, busy, done, err, overflow;
  logic [7:0]  imem_addr, err_count;
  logic [15:0] imem_wdata;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  bit m_load = 1'b0;
  int m_wptr = 0;
  int m_errcnt = 0;
  bit m_ovf = 1'b0;

  always #5 clk = ~clk;

  risc_instr_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
    .in_imm(in_imm), .in_last(in_last), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy),
    .done(done), .err(err), .err_count(err_count), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_itype(input int op);
    return (op == 0) || (op == 1) || (op == 11) || (op == 12);
  endfunction

  function automatic bit m_legal(input int op, input int imm);
    int s;
    if (op == 10 || op == 14 || op == 15) return 1'b0;
    if (m_itype(op)) begin
      s = (imm >= 2048) ? imm - 4096 : imm;
      return (s >= -32) && (s <= 31);
    end
    return 1'b1;
  endfunction

  function automatic int m_word(input int op, input int rs, input int rt, input int rd,
                                input int fn, input int imm);
    if (op == 13) return op * 4096 + imm;
    if (m_itype(op)) return op * 4096 + rs * 512 + rt * 64 + (imm % 64);
    return op * 4096 + rs * 512 + rt * 64 + rd * 8 + fn;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    m_load = 1'b0; m_wptr = 0; m_errcnt = 0; m_ovf = 1'b0;
    chk("rst_we", imem_we, 0);      chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0); chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);        chk("rst_done", done, 0);
    chk("rst_err", err, 0);          chk("rst_errcnt", err_count, 0);
    chk("rst_ovf", overflow, 0);
  endtask

  task automatic start_sess(input int addr, input bit with_beat);
    start = 1'b1; start_addr = addr[7:0];
    in_valid = with_beat; in_opcode = 4'd2; in_last = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    m_load = 1'b1; m_wptr = addr; m_errcnt = 0; m_ovf = 1'b0;
    chk("start_we", imem_we, 0);   chk("start_err", err, 0);
    chk("start_errcnt", err_count, 0); chk("start_ovf", overflow, 0);
    chk("start_done", done, 0);    chk("start_busy", busy, 1);
  endtask

  task automatic beat(input int op, input int rs, input int rt, input int rd,
                      input int fn, input int imm, input bit last, input bit valid);
    bit acc;
    in_opcode = op[3:0]; in_rs = rs[2:0]; in_rt = rt[2:0]; in_rd = rd[2:0];
    in_funct = fn[2:0]; in_imm = imm[11:0]; in_last = last; in_valid = valid;
    chk("in_ready", in_ready, m_load);
    acc = valid && m_load;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    if (acc) begin
      if (m_legal(op, imm)) begin
        chk("wr_we", imem_we, 1);
        chk("wr_addr", imem_addr, m_wptr);
        chk("wr_data", imem_wdata, m_word(op, rs, rt, rd, fn, imm));
        chk("wr_err", err, 0);
        if (m_wptr == 255) begin m_ovf = 1'b1; m_load = 1'b0; end
        m_wptr = (m_wptr + 1) % 256;
      end else begin
        chk("rej_we", imem_we, 0);
        chk("rej_err", err, 1);
        if (m_errcnt < 255) m_errcnt++;
      end
      if (last) m_load = 1'b0;
    end else begin
      chk("idle_we", imem_we, 0);
      chk("idle_err", err, 0);
    end
    chk("err_count", err_count, m_errcnt);
    chk("overflow", overflow, m_ovf);
    chk("busy", busy, m_load);
    if (m_load) chk("done_low", done, 0);
  endtask

  task automatic check_done();
    @(posedge clk); #1;
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_ready", in_ready, 0);
  endtask

  initial begin
    int accepted;
    int op, imm;
    bit v;
    reset = 1'b1; start = 1'b0; start_addr = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    in_opcode = 4'd0; in_rs = 3'd0; in_rt = 3'd0; in_rd = 3'd0; in_funct = 3'd0;
    in_imm = 12'd0;
    @(posedge clk); #1;
    do_reset();

    // beat offered while idle is not accepted
    beat(2, 1, 1, 1, 1, 0, 1'b0, 1'b1);

    // case 1: single R-type with last
    start_sess(8'h10, 1'b0);
    beat(2, 1, 2, 3, 5, 0, 1'b1, 1'b1);
    check_done();

    // case 2: LW with negative imm, then out-of-range imm
    start_sess(8'h20, 1'b0);
    beat(0, 2, 4, 0, 0, 12'hFFD, 1'b0, 1'b1);
    chk("lw_word", imem_wdata, 16'h053D);
    beat(0, 2, 4, 0, 0, 12'h020, 1'b0, 1'b1);

    // case 3: illegal opcode then jmp ending the session
    beat(14, 1, 1, 1, 1, 0, 1'b0, 1'b1);
    beat(13, 0, 0, 0, 0, 12'hABC, 1'b1, 1'b1);
    chk("jmp_word", imem_wdata, 16'hDABC);
    check_done();

    // case 4: address wrap; third beat refused
    start_sess(8'hFE, 1'b0);
    beat(3, 1, 2, 3, 4, 0, 1'b0, 1'b1);
    beat(4, 2, 3, 4, 5, 0, 1'b0, 1'b1);
    beat(5, 3, 4, 5, 6, 0, 1'b0, 1'b1);
    check_done();
    chk("wrap_ovf", overflow, 1);

    // case 5: reset concurrent with a beat discards it; start mid-load reloads
    start_sess(8'h30, 1'b0);
    in_opcode = 4'd2; in_valid = 1'b1;
    do_reset();
    start_sess(8'h30, 1'b0);
    beat(15, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    start_sess(8'h50, 1'b1);
    beat(6, 7, 6, 5, 4, 0, 1'b0, 1'b1);

    // case 6: random valid gaps and random fields
    start_sess(8'h60, 1'b0);
    accepted = 0;
    for (int c = 0; c < 200 && accepted < 20; c++) begin
      v = 1'($urandom_range(0, 1));
      if (v) accepted++;
      op = $urandom_range(0, 15);
      imm = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4095)
                                        : (($urandom_range(0, 63) + 4064) % 4096);
      beat(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), imm, 1'b0, v);
    end
    chk("rand_beats", accepted, 20);
    beat(9, 1, 2, 3, 4, 0, 1'b1, 1'b1);
    check_done();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
